// File: rtl/data_bus_controller_if.sv
// Load/store handshake between the CPU pipeline (master) and the data bus controller (slave).
interface data_bus_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  unsigned_value;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  ready;
  logic                  valid;
  logic [31:0]           rdata;
  logic                  exc;

  modport master (output req, we, size, unsigned_value, addr, wdata,
                  input  ready, valid, rdata, exc);
  modport slave  (input  req, we, size, unsigned_value, addr, wdata,
                  output ready, valid, rdata, exc);
endinterface

// File: rtl/data_bus_controller.sv
// Data-side bus controller: RAM load/store with sub-word merge/extend, W1C fault STATUS, access counter.
// Optional FAULT_ADDR capture register enabled by defining DBC_FAULT_ADDR_EN.
module data_bus_controller #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          RAM_WORDS   = 1024,
  parameter logic [31:0] RAM_START   = 32'h0000_1000,
  parameter logic [31:0] REG_BASE    = 32'hFFFF_0000,
  parameter int          WAIT_STATES = 1
) (
  input logic                 clk,
  input logic                 rst,
  data_bus_controller_if.slave bus
);
  localparam int                    IDX_W     = $clog2(RAM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] RAM_LO    = ADDR_WIDTH'(RAM_START);
  localparam logic [ADDR_WIDTH:0]   RAM_BYTES = (ADDR_WIDTH+1)'(4 * RAM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] REG_LO    = ADDR_WIDTH'(REG_BASE);
  localparam logic [3:0]            WS_INIT   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  state_t                state, nstate;
  req_t                  cur;
  logic [3:0]            wcnt;
  logic [1:0]            status;
  logic [31:0]           count;
  logic [31:0]           fault_rd;
  logic [31:0]           ram [RAM_WORDS];

  // Decode on the latched request
  logic [ADDR_WIDTH-1:0] ram_off, reg_off;
  logic                  ram_hit, reg_hit, mis, empty, fault, resp;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            lane;

  assign ram_off = cur.addr - RAM_LO;
  assign reg_off = cur.addr - REG_LO;
  assign ram_hit = (cur.addr >= RAM_LO) && ({1'b0, ram_off} < RAM_BYTES);
  assign reg_hit = (cur.addr >= REG_LO) && (reg_off < ADDR_WIDTH'(12));
  assign idx     = ram_off[IDX_W+1:2];
  assign lane    = cur.addr[1:0];
  assign mis     = (cur.size == 2'b11) ||
                   (cur.size == 2'b01 && lane[0]) ||
                   (cur.size == 2'b10 && lane != 2'b00) ||
                   (reg_hit && cur.size != 2'b10);
  assign empty   = !ram_hit && !reg_hit;
  assign fault   = mis || empty;
  assign resp    = (state == S_RESP);

  // Lane merge: replicate store data across lanes, enable only the addressed ones
  logic [3:0][7:0] old_w, new_w, wrep;
  logic [3:0]      be;

  assign old_w = ram[idx];
  assign wrep  = (cur.size == 2'b00) ? {4{cur.wdata[7:0]}} :
                 (cur.size == 2'b01) ? {2{cur.wdata[15:0]}} : cur.wdata;

  always_comb begin
    be = 4'b0000;
    case (cur.size)
      2'b00:   be[lane] = 1'b1;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign new_w[l] = be[l] ? wrep[l] : old_w[l];
  end

  always_ff @(posedge clk) begin
    if (resp && cur.we && ram_hit && !fault) ram[idx] <= new_w;
  end

  // Load path: RAM extract/extend or register read
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld, reg_rd, rd_val;

  assign ld_b = old_w[lane];
  assign ld_h = lane[1] ? old_w[3:2] : old_w[1:0];

  always_comb begin
    case (cur.size)
      2'b00:   ld = {{24{ld_b[7] & ~cur.uns}}, ld_b};
      2'b01:   ld = {{16{ld_h[15] & ~cur.uns}}, ld_h};
      default: ld = old_w;
    endcase
  end

  always_comb begin
    case (reg_off[3:2])
      2'd0:    reg_rd = {30'b0, status};
      2'd1:    reg_rd = fault_rd;
      2'd2:    reg_rd = count;
      default: reg_rd = 32'h0;
    endcase
  end

  assign rd_val = reg_hit ? reg_rd : ld;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  // FSM: next state
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (bus.req) nstate = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (wcnt == 4'd0) nstate = S_RESP;
      S_RESP: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.ready = (state == S_IDLE);
    bus.valid = resp;
    bus.exc   = resp && fault;
    bus.rdata = (resp && !fault && !cur.we) ? rd_val : 32'h0;
  end

  // Request latch, wait counter, STATUS and ACCESS_COUNT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur    <= '0;
      wcnt   <= 4'd0;
      status <= 2'b00;
      count  <= 32'h0;
    end else begin
      if (state == S_IDLE && bus.req) begin
        cur  <= '{we: bus.we, size: bus.size, uns: bus.unsigned_value,
                  addr: bus.addr, wdata: bus.wdata};
        wcnt <= WS_INIT;
      end else if (state == S_WAIT && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
      if (resp) begin
        count <= count + 32'd1;
        // A faulting W1C store must not clear: fault set wins
        if (fault)
          status <= status | {empty, mis};
        else if (cur.we && reg_hit && reg_off[3:2] == 2'd0)
          status <= status & ~cur.wdata[1:0];
      end
    end
  end

`ifdef DBC_FAULT_ADDR_EN
  logic [ADDR_WIDTH-1:0] fault_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               fault_addr <= '0;
    else if (resp && fault && status == 2'b00) fault_addr <= cur.addr;
  end

  assign fault_rd = 32'(fault_addr);
`else
  assign fault_rd = 32'h0;
`endif

endmodule

// File: doc/data_bus_controller.md
Name: data_bus_controller

Overview:
- Parametrised successor to the core's data-side bus controller: single load/store port between the CPU pipeline and on-chip data RAM plus a small block of memory-mapped controller registers.
- Adds a req/ready/valid handshake with configurable wait states.
- Adds byte-addressed sub-word stores with lane merging, and sign/zero-extended sub-word loads.
- Adds sticky write-1-to-clear exception status and an access counter.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- RAM_WORDS, 1024, number of 32-bit RAM words (power of two).
- RAM_START, 32'h0000_1000, byte address of the first RAM word.
- REG_BASE, 32'hFFFF_0000, byte address of the controller register block (3 words).
- WAIT_STATES, 1, extra cycles between accept and response (0..15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  access request; sampled only while ready=1.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- unsigned_value  input  1  load zero-extends when 1, sign-extends when 0.
- addr  input  ADDR_WIDTH  byte address.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  output  1  1 = idle, request can be accepted this cycle.
- valid  output  1  one-cycle response strobe.
- rdata  output  32  load result, extended; valid only while valid=1.
- exc  output  1  high with valid when the access faulted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ready=1, valid=0, exc=0, rdata=0.
  - STATUS=0, ACCESS_COUNT=0, wait counter=0.
  - RAM contents are not reset.
- FSM IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: ready=1. On req=1, latch we/size/unsigned_value/addr/wdata. Go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: ready=0. Stay WAIT_STATES cycles, counting down, then go to RESP.
  - RESP: ready=0, valid=1 for exactly one cycle, then return to IDLE.
  - Accept-to-valid latency is WAIT_STATES+1 cycles.
  - Back-to-back requests: next accept earliest the cycle after RESP. Inputs changing after accept are ignored.
- Decode (on latched address):
  - RAM hit: RAM_START <= addr < RAM_START+4*RAM_WORDS.
  - Word index = (addr-RAM_START)>>2. Lane = addr[1:0].
  - Register hit: addr in REG_BASE..REG_BASE+11.
  - Misaligned: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; size=11 always; register access with size!=10.
  - Empty-address: neither RAM hit nor register hit.
  - Fault = misaligned OR empty-address.
- Store to RAM (no fault): committed on the clock edge leaving RESP.
  - Byte: write lane addr[1:0] with wdata[7:0].
  - Half: write lanes addr[1]*2+{0,1} with wdata[15:0].
  - Word: write the whole word.
  - All other lanes are preserved.
- Load from RAM:
  - rdata = selected byte or half shifted to bit 0, then extended per unsigned_value.
  - Word loads ignore unsigned_value.
  - Load from the same word in the cycle after a store completes returns the new data.
- Registers:
  - REG_BASE+0 STATUS: bit0 misaligned, bit1 empty-address, other bits read 0. Sticky; set at RESP of a faulting access. A word store writing 1 to a bit clears that bit.
  - REG_BASE+4 FAULT_ADDR: see the optional feature.
  - REG_BASE+8 ACCESS_COUNT: read-only. Increments at every RESP, faulting or not, including register accesses. Wraps 32'hFFFF_FFFF -> 0.
- Faulting access: no RAM or register write, rdata=0, exc=1 with valid, STATUS bit(s) set.
- Simultaneous events: a W1C store to STATUS that itself faults (unaligned) does not clear; fault set has priority.
- Reset mid-operation: the access is abandoned, no write is committed, and valid is never raised.

Optional Feature:
- Macro: DBC_FAULT_ADDR_EN.
- Defined: FAULT_ADDR register implemented.
  - Captures the latched addr of the first fault while STATUS==0; not overwritten while any STATUS bit remains set.
  - Reset value 0. Read-only; writes are ignored.
- Undefined: FAULT_ADDR reads 0, stores to it are ignored, and no capture logic is generated.

Test Plan:
- Reset, then word store 32'hDEADBEEF at RAM_START+8, then word load -> valid exactly WAIT_STATES+1 cycles after accept, rdata=32'hDEADBEEF, exc=0, ready low in between.
- Byte store 8'h80 at RAM_START+9 over 32'hDEADBEEF, then byte load with unsigned_value=0 -> rdata=32'hFFFFFF80. Word load -> 32'hDEAD80EF.
- Half load at RAM_START+10 with unsigned_value=1 -> 32'h0000DEAD. Same with unsigned_value=0 -> 32'hFFFFDEAD.
- Word load at RAM_START+2 -> exc=1, rdata=0, STATUS=1. FAULT_ADDR=RAM_START+2 with DBC_FAULT_ADDR_EN, 0 without. Store 1 to STATUS -> STATUS=0.
- Load at 32'h0000_0004 (unmapped) -> exc=1, STATUS bit1=1, no RAM change. ACCESS_COUNT increments across all of the above.
- rst pulled low during WAIT of a word store -> ready=1 immediately, no valid, RAM word unchanged, STATUS=0.
